// File: rtl/r_division_signed_pkg.sv
// Shared definitions for the sequential signed restoring divider.
//   state_e   : divider FSM states (LOAD -> ITER -> DONE)
//   cnt_width : width of the iteration counter for an N-bit divider
package r_division_signed_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter must represent 0..N, hence clog2(N+1).
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/r_div_magnitude.sv
// Combinational N-bit conditional two's-complement negate.
// Used as abs() when neg_i is tied to the operand's sign bit, and as the
// result sign correction when neg_i is a captured sign flag.
//   a_i   in  N  operand
//   neg_i in  1  1 = output -a_i, 0 = output a_i
//   y_o   out N  result (for abs of -2^(N-1) this is 2^(N-1) read unsigned)
module r_div_magnitude #(
    parameter int N = 9
) (
    input  logic [N-1:0] a_i,
    input  logic         neg_i,
    output logic [N-1:0] y_o
);

    // Select between pass-through and two's-complement negation.
    always_comb begin
        y_o = a_i;
        if (neg_i) begin
            y_o = ~a_i + {{(N-1){1'b0}}, 1'b1};
        end else begin
            y_o = a_i;
        end
    end

endmodule

// File: rtl/r_division_signed.sv
// Sequential signed restoring divider, one quotient bit per clock.
// Releasing rst starts a division; the result appears N+1 rising edges later
// and holds until the next rst pulse. Quotient truncates toward zero, the
// remainder takes the dividend's sign. Divide by zero yields an all-ones
// quotient and the dividend as remainder.
//   clk   in  1   clock, rising edge
//   rst   in  1   asynchronous active-high reset; release starts a division
//   dd_in in  N   signed dividend (sampled on first edge after release)
//   dr_in in  N   signed divisor  (sampled on first edge after release)
//   out   out 2N  {remainder, quotient}, signed
module r_division_signed
    import r_division_signed_pkg::*;
#(
    parameter int N = 9
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   dd_in,
    input  logic [N-1:0]   dr_in,
    output logic [2*N-1:0] out
);

    localparam int CW = cnt_width(N);

    state_e          state_q, state_d;
    logic [N:0]      accu, accu_d;     // partial remainder magnitude
    logic [N-1:0]    dd, dd_d;         // dividend shifting out, quotient shifting in
    logic [N-1:0]    dr_q, dr_d;       // divisor magnitude
    logic            quot_neg_q, quot_neg_d;
    logic            rem_neg_q, rem_neg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*N-1:0]  out_q, out_d;

    logic [N-1:0]    dd_abs_s, dr_abs_s;
    logic [N+1:0]    sh_s, trial_s;
    logic [N:0]      accu_step_s;
    logic [N-1:0]    dd_step_s;
    logic [N-1:0]    quot_s, rem_s;

    // Operand conditioning: unsigned magnitudes of the inputs.
    r_div_magnitude #(.N(N)) u_abs_dd (.a_i(dd_in), .neg_i(dd_in[N-1]), .y_o(dd_abs_s));
    r_div_magnitude #(.N(N)) u_abs_dr (.a_i(dr_in), .neg_i(dr_in[N-1]), .y_o(dr_abs_s));

    // One restoring step. sh_s carries an extra top bit so the sign of the
    // trial subtraction is visible without losing accu's MSB.
    assign sh_s        = {accu, dd[N-1]};
    assign trial_s     = sh_s - {2'b00, dr_q};
    assign accu_step_s = trial_s[N+1] ? sh_s[N:0] : trial_s[N:0];
    assign dd_step_s   = {dd[N-2:0], ~trial_s[N+1]};

    // Sign correction of the values the final step will produce.
    r_div_magnitude #(.N(N)) u_neg_quot (.a_i(dd_step_s), .neg_i(quot_neg_q), .y_o(quot_s));
    r_div_magnitude #(.N(N)) u_neg_rem  (.a_i(accu_step_s[N-1:0]), .neg_i(rem_neg_q), .y_o(rem_s));

    // Next-state and datapath update for LOAD / ITER / DONE.
    always_comb begin
        state_d    = state_q;
        accu_d     = accu;
        dd_d       = dd;
        dr_d       = dr_q;
        quot_neg_d = quot_neg_q;
        rem_neg_d  = rem_neg_q;
        cnt_d      = cnt_q;
        out_d      = out_q;
        case (state_q)
            LOAD: begin
                quot_neg_d = dd_in[N-1] ^ dr_in[N-1];
                rem_neg_d  = dd_in[N-1];
                dd_d       = dd_abs_s;
                dr_d       = dr_abs_s;
                accu_d     = {(N+1){1'b0}};
                cnt_d      = {CW{1'b0}};
                state_d    = ITER;
            end
            ITER: begin
                accu_d = accu_step_s;
                dd_d   = dd_step_s;
                cnt_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                    // A zero divisor always reports an all-ones quotient,
                    // regardless of the dividend's sign.
                    if (dr_q == {N{1'b0}}) begin
                        out_d = {rem_s, {N{1'b1}}};
                    end else begin
                        out_d = {rem_s, quot_s};
                    end
                end else begin
                    state_d = ITER;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // State and datapath registers, cleared by asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= LOAD;
            accu       <= {(N+1){1'b0}};
            dd         <= {N{1'b0}};
            dr_q       <= {N{1'b0}};
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            cnt_q      <= {CW{1'b0}};
            out_q      <= {(2*N){1'b0}};
        end else begin
            state_q    <= state_d;
            accu       <= accu_d;
            dd         <= dd_d;
            dr_q       <= dr_d;
            quot_neg_q <= quot_neg_d;
            rem_neg_q  <= rem_neg_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_r_division_signed.sv
// Scoreboard bench for r_division_signed: stimulus pushes hand-computed
// {remainder, quotient} values, a monitor counts edges since reset release
// and compares at the result edge, before it (must be 0) and after (hold).
module tb_r_division_signed;

    localparam int N = 9;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   dd_in = '0;
    logic [N-1:0]   dr_in = '0;
    logic [2*N-1:0] out;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;

    logic [2*N-1:0] exp_q[$];
    logic [2*N-1:0] held = '0;

    r_division_signed #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .dd_in (dd_in),
        .dr_in (dr_in),
        .out   (out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [2*N-1:0] pk(input int q, input int r);
        logic [N-1:0] qq;
        logic [N-1:0] rr;
        qq = q[N-1:0];
        rr = r[N-1:0];
        return {rr, qq};
    endfunction

    // Edges since reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt = 0;
        else     edge_cnt = edge_cnt + 1;
    end

    // Monitor: sample on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_out", 32'(out), 32'd0);
            chk("rst_accu", 32'(dut.accu), 32'd0);
            chk("rst_dd", 32'(dut.dd), 32'd0);
        end else if (edge_cnt >= 1 && edge_cnt <= N) begin
            chk("busy_out", 32'(out), 32'd0);
        end else if (edge_cnt == N + 1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL result_queue actual=empty required=entry");
            end else begin
                held = exp_q.pop_front();
                chk("result", 32'(out), 32'(held));
            end
        end else if (edge_cnt == N + 3) begin
            chk("hold", 32'(out), 32'(held));
        end
    end

    task automatic run(input int a, input int b, input int q, input int r);
        @(negedge clk);
        #2 rst = 1'b1;
        dd_in = a[N-1:0];
        dr_in = b[N-1:0];
        exp_q.push_back(pk(q, r));
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (N + 2) @(negedge clk);
        // Inputs must be ignored once DONE.
        dd_in = ~dd_in;
        dr_in = dr_in + 9'd1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        run( 221,    3,   73,   2);
        run(-178,   32,   -5, -18);
        run( 100,   -7,  -14,   2);
        run(-100,   -7,   14,  -2);
        run(-256,   -1, -256,   0);
        run(-256,    1, -256,   0);
        run(  55,    0,   -1,  55);
        run( -55,    0,   -1, -55);
        run(   5,    9,    0,   5);
        run( 255, -256,    0, 255);
        run(-256, -256,    1,   0);

        // Abort mid-iteration, then restart with new operands.
        @(negedge clk);
        #2 rst = 1'b1;
        dd_in = 9'd100;
        dr_in = 9'h1F9;
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_out", 32'(out), 32'd0);
        chk("abort_accu", 32'(dut.accu), 32'd0);
        chk("abort_dd", 32'(dut.dd), 32'd0);
        dd_in = 9'd221;
        dr_in = 9'd3;
        exp_q.push_back(pk(73, 2));
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (N + 5) @(negedge clk);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
